// File: rtl/iter_downcount_pkg.sv
// Shared types and constants for the iteration down counter.
package iter_downcount_pkg;

    // Default count width; maximum iteration count is 2^ITER_WIDTH-1.
    localparam int unsigned ITER_WIDTH = 6;

    // Controller states; the unused encoding 2'b11 is decoded as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } iter_state_t;

endpackage

// File: rtl/loadable_tff.sv
// One count bit: T flip-flop with asynchronous clear and synchronous load.
// Load takes priority over toggle.
module loadable_tff (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic d,
    input  logic t,
    output logic q
);

    // Bit state: clear, then load, then toggle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= 1'b0;
        end else if (load) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/iter_downcounter.sv
// Loadable down counter with start/busy/done handshake.
// Optional feature macro: ITER_DOWNCOUNT_HOLD_EN adds a 'hold' input that
// freezes the count while running.
module iter_downcounter
    import iter_downcount_pkg::*;
#(
    parameter int unsigned WIDTH = ITER_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
`ifdef ITER_DOWNCOUNT_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

`ifndef ITER_DOWNCOUNT_HOLD_EN
    logic hold;
    assign hold = 1'b0;
`endif

    iter_state_t      state_q, state_d;
    logic             busy_q, done_q;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             run_en;
    logic             count_is_one;
    logic [WIDTH-1:0] borrow;

    assign count_is_one = (count == WIDTH'(1));
    assign run_en       = (state_q == RUN) && !hold;

    // Next-state and load decode; IDLE and DONE both accept a new start.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_data = load_val;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    load    = 1'b1;
                    state_d = (load_val == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!hold && count_is_one) begin
                    state_d = DONE;
                end
            end
            default: begin
                // Unused encoding behaves as IDLE and scrubs any stale count.
                state_d   = IDLE;
                load      = 1'b1;
                load_data = '0;
                if (start) begin
                    load_data = load_val;
                    state_d   = (load_val == '0) ? DONE : RUN;
                end
            end
        endcase
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Borrow chain: bit i toggles when every lower bit is zero.
    assign borrow[0] = run_en;
    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign borrow[i] = borrow[i-1] & ~count[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        loadable_tff u_bit (
            .clk  (clk),
            .clr  (clr),
            .load (load),
            .d    (load_data[i]),
            .t    (borrow[i]),
            .q    (count[i])
        );
    end

    // Final-iteration flag, suppressed while held.
    always_comb begin
        last = (state_q == RUN) && count_is_one && !hold;
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_iter_downcounter.sv
// Scoreboard bench for iter_downcounter: the driver pushes the expected
// outputs for each cycle it drives, the monitor pops and compares at negedge.
module tb_iter_downcounter;

    localparam int unsigned W = 6;

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         last;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [W-1:0] load_val;
    logic         hold;
    logic [W-1:0] count;
    logic         busy, last, done;

    exp_t exp_q[$];
    int   applied     = 0;
    int   miscompares = 0;

    iter_downcounter #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .load_val (load_val),
`ifdef ITER_DOWNCOUNT_HOLD_EN
        .hold     (hold),
`endif
        .count    (count),
        .busy     (busy),
        .last     (last),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue the outputs
    // expected for that cycle.
    task automatic step(input logic c, input logic s, input logic [W-1:0] lv, input logic h,
                        input logic [W-1:0] ec, input logic eb, input logic el,
                        input logic ed);
        exp_t e;
        @(posedge clk);
        #1;
        clr      = c;
        start    = s;
        load_val = lv;
        hold     = h;
        e.count  = ec;
        e.busy   = eb;
        e.last   = el;
        e.done   = ed;
        exp_q.push_back(e);
    endtask

    // Plain countdown from n (already loaded) through done and one idle cycle.
    task automatic run_out(input int n);
        for (int k = n; k >= 1; k--) begin
            step(1'b0, 1'b0, '0, 1'b0, W'(k), 1'b1, (k == 1), 1'b0);
        end
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every queued expectation against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                applied++;
                if (count !== e.count || busy !== e.busy || last !== e.last ||
                    done !== e.done) begin
                    miscompares++;
                    $display("FAIL vec%0d: got count=%0d busy=%b last=%b done=%b, want count=%0d busy=%b last=%b done=%b",
                             applied, count, busy, last, done, e.count, e.busy, e.last,
                             e.done);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        load_val = '0;
        hold     = 1'b0;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), W'($urandom), 1'($urandom), '0, 1'b0, 1'b0, 1'b0);
        end

        // N=5 right after reset release.
        step(1'b0, 1'b1, 6'd5, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        run_out(5);

        // N=0: done next cycle, never busy.
        step(1'b0, 1'b1, 6'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 6'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // N=63: full range, no wrap.
        step(1'b0, 1'b1, 6'd63, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        run_out(63);

        // start held through a run of 3, load_val changed to 9 mid-run;
        // the start seen in DONE launches N=9 back to back.
        step(1'b0, 1'b1, 6'd3, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd3, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd9, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd9, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        run_out(9);

        // clr mid-run of N=4 while count=2: immediate clear, no done.
        step(1'b0, 1'b1, 6'd4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 6'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 6'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        end

`ifdef ITER_DOWNCOUNT_HOLD_EN
        // N=4 with hold for 3 edges at count=2, then hold at count=1.
        step(1'b0, 1'b1, 6'd4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 6'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
`else
        // Same N=4 run with nothing to hold it: completes in 4 cycles.
        step(1'b0, 1'b1, 6'd4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        run_out(4);
`endif

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/iter_downcounter.md
# iter_downcounter

Loadable down counter with start/busy/done handshake that sequences iteration counts for the multiply/divide datapath. A controller loads an iteration count N. The block decrements once per clock through a T-flip-flop borrow chain. It reports termination with a one-cycle `done` pulse. It complements the existing free-running up counter: it consumes a programmed count instead of producing one, and it terminates instead of wrapping.

## Interface
Parameters:
- `WIDTH`, default 6: count width. The maximum iteration count is 2^WIDTH−1.

Ports (reset clr, asynchronous, active-high; clock clk):
- `clk`  in  1  clock; all state updates on the rising edge
- `clr`  in  1  asynchronous active-high reset
- `start`  in  1  request to load `load_val` and begin counting
- `load_val`  in  WIDTH  iteration count N, sampled only when `start` is accepted
- `hold`  in  1  freeze the count while running; present only with `ITER_DOWNCOUNT_HOLD_EN`
- `count`  out  WIDTH  current remaining count
- `busy`  out  1  high while state is RUN
- `last`  out  1  high when state is RUN, `count`==1 and not held; marks the final iteration
- `done`  out  1  one-cycle registered pulse marking termination

## Operation
- States:
  - IDLE: `count`=0, `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1, `busy`=0.
- IDLE, `start`=1, `load_val`=N≠0: go to RUN with `count`=N.
- IDLE, `start`=1, `load_val`=0: go straight to DONE with `count`=0. This is a zero-length operation.
- IDLE, `start`=0: stay in IDLE.
- RUN: each cycle `count` ← `count`−1.
  - Decrement uses the borrow chain: bit i toggles when bits [i−1:0] are all 0; bit 0 always toggles.
  - When `count`==1 the next state is DONE with `count`=0.
- RUN ignores `start`. `load_val` is not re-sampled.
- DONE lasts exactly one cycle.
  - `start`=1 in DONE is accepted, with the same rules as in IDLE. `done` is still high that cycle.
  - Otherwise DONE returns to IDLE.
- The count never wraps. `count`=0 never occurs in RUN.
- `clr` at any time, including mid-RUN: immediately forces IDLE, `count`=0, `busy`=0, `done`=0, `last`=0. An aborted run produces no `done`.

## Timing
- Reset values: `count`=0, `busy`=0, `last`=0, `done`=0. State is IDLE.
- `count`, `busy` and `done` are registered. `last` is combinational from registered state.
- Let E0 be the clock edge that samples `start`.
  - `done` is high for the cycle following edge E0+N (hold cycles extend this).
  - N=0: `done` rises after E0.
  - N=1: `busy` is high for one cycle, then `done`.
  - `busy` is high for exactly N cycles.
- Back-to-back operation: `start` during the DONE cycle gives zero idle cycles between runs.
- `clr` deassertion is synchronous to `clk` at the system level. The first `start` can be accepted on the first edge after `clr` falls.

## Configuration
- Macro `ITER_DOWNCOUNT_HOLD_EN`.
- Defined:
  - The `hold` port exists.
  - `hold`=1 in RUN freezes `count` and state, and forces `last`=0.
  - `hold` is ignored in IDLE and DONE.
  - `clr` overrides `hold`.
- Undefined: no `hold` port. Behaviour is identical to `hold` tied 0.

## Structure
- Package `iter_downcount_pkg` contains:
  - the state typedef `iter_state_t`: IDLE=2'b00, RUN=2'b01, DONE=2'b10, with 2'b11 decoding to IDLE;
  - the default width constant `ITER_WIDTH`=6.
- Sub-module `loadable_tff`: one count bit, instantiated WIDTH times.
  - Asynchronous clear.
  - Synchronous load (load has priority over toggle).
  - Toggle-enable input driven by the borrow chain.
- The top level holds the FSM, the borrow-chain AND gates, and the `last` and `done` logic.

## Test plan
- Reset: assert `clr` with random inputs → `count`=0, `busy`=0, `done`=0, `last`=0. Then release and apply `start` with `load_val`=5 → `count` sequence 5,4,3,2,1,0; `busy` high 5 cycles; `last` high while `count`=1; `done` high for 1 cycle.
- Boundaries: `load_val`=0 → `done` pulses on the next cycle with `busy` never high. `load_val`=63 → 63 busy cycles, then `done`, with `count` never wrapping to 63.
- `start`=1 throughout a run with `load_val`=3, then `load_val` changed to 9 mid-run → run unaffected; a new run with N=9 starts in the DONE cycle; `done` and `busy` are never high together.
- `clr` pulse while `count`=2 in a run of N=4 → immediate `count`=0 and `busy`=0; no `done` ever pulses.
- With `ITER_DOWNCOUNT_HOLD_EN`: N=4, `hold` high for 3 cycles while `count`=2 → `count` stays 2 and `last`=0; `done` arrives 3 cycles later than unheld. Without the macro, the same run completes in 4 cycles.
